// File: rtl/perf_event_sampler.sv
// perf_event_sampler
//
// Purpose:
//   Parametrised bank of CHANNEL_NUM event counters plus a free-running cycle
//   stamp. Each counter takes a multi-event increment per cycle, so
//   commit-width events can be counted directly. A snapshot request captures
//   the stamp and all counters into a small FIFO. The FIFO is streamed out one
//   word per beat over a valid/ready port: beat 0 is the stamp and beat c+1
//   is counter c.
//
// Optional feature (macro RSD_PERF_COUNTER_SATURATE_EN):
//   When defined, counters saturate at all-ones instead of wrapping. A
//   per-channel sticky overflow bit records that saturation happened. While
//   the sticky bit is set, every captured word for that channel has its MSB
//   forced to 1. Only clearReq or reset clears the sticky bits. The cycle
//   stamp always wraps. When the macro is undefined, counters wrap modulo
//   2^COUNTER_WIDTH.
//
// Ports:
//   clk, rst      - clock, asynchronous active-high reset
//   enable        - counters and stamp advance only while high
//   eventInc      - per-channel increment, channel c at [c*INC_WIDTH +: INC_WIDTH]
//   clearReq      - zero all counters and the stamp (wins over increment)
//   snapshotReq   - capture the stamp and counters (pre-update values) into the FIFO
//   outValid/outReady/outData/outChannel/outLast - snapshot stream
//   fifoCount     - snapshots currently held
//   dropCount     - snapshots lost to a full FIFO, saturating at 255

module perf_event_sampler #(
  parameter int CHANNEL_NUM    = 8,
  parameter int COUNTER_WIDTH  = 32,
  parameter int INC_WIDTH      = 2,
  parameter int SNAPSHOT_DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enable,
  input  logic [CHANNEL_NUM*INC_WIDTH-1:0]      eventInc,
  input  logic                                  clearReq,
  input  logic                                  snapshotReq,
  output logic                                  outValid,
  input  logic                                  outReady,
  output logic [COUNTER_WIDTH-1:0]              outData,
  output logic [$clog2(CHANNEL_NUM+1)-1:0]      outChannel,
  output logic                                  outLast,
  output logic [$clog2(SNAPSHOT_DEPTH+1)-1:0]   fifoCount,
  output logic [7:0]                            dropCount
);

  localparam int CH_W  = $clog2(CHANNEL_NUM + 1);
  // The depth is a power of two, so the count width equals the index width
  // plus one. That extra bit is the wrap bit of each pointer.
  localparam int CNT_W = $clog2(SNAPSHOT_DEPTH + 1);
  localparam int IDX_W = CNT_W - 1;
  localparam int WORDS = CHANNEL_NUM + 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  // Counter state
  logic [COUNTER_WIDTH-1:0] cnt_q   [CHANNEL_NUM];
  logic [COUNTER_WIDTH-1:0] cnt_d   [CHANNEL_NUM];
  logic [COUNTER_WIDTH-1:0] stamp_q;
  logic [COUNTER_WIDTH-1:0] stamp_d;
`ifdef RSD_PERF_COUNTER_SATURATE_EN
  logic [CHANNEL_NUM-1:0]   sticky_q;
  logic [CHANNEL_NUM-1:0]   sticky_d;
  logic [COUNTER_WIDTH:0]   sat_sum [CHANNEL_NUM];
`endif

  // Snapshot FIFO
  logic [COUNTER_WIDTH-1:0] fifo_mem [SNAPSHOT_DEPTH][WORDS];
  logic [COUNTER_WIDTH-1:0] snap_word [WORDS];
  logic [CNT_W-1:0]         head_q;
  logic [CNT_W-1:0]         head_d;
  logic [CNT_W-1:0]         tail_q;
  logic [CNT_W-1:0]         tail_d;
  logic [CNT_W-1:0]         fifo_count_d;
  logic [7:0]               drop_q;
  logic [7:0]               drop_d;
  logic                     fifo_empty;
  logic                     fifo_full;
  logic                     pop;
  logic                     push;
  logic                     drop;

  // Stream FSM
  state_t                   state_q;
  state_t                   state_d;
  logic [CH_W-1:0]          beat_q;
  logic [CH_W-1:0]          beat_d;
  logic [CH_W-1:0]          beat_inc;
  logic                     valid_q;
  logic                     valid_d;
  logic                     last_q;
  logic                     last_d;

  // ---------------------------------------------------------------------------
  // Counter update. Clear has priority and discards the same-cycle increment.
  // ---------------------------------------------------------------------------
`ifdef RSD_PERF_COUNTER_SATURATE_EN
  // The extra top bit of each sum is the overflow (carry-out) of that channel.
  always_comb begin
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      sat_sum[c] = {1'b0, cnt_q[c]}
                 + (COUNTER_WIDTH+1)'(eventInc[c*INC_WIDTH +: INC_WIDTH]);
    end
  end
`endif

  always_comb begin
    stamp_d = stamp_q;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      cnt_d[c] = cnt_q[c];
    end
`ifdef RSD_PERF_COUNTER_SATURATE_EN
    sticky_d = sticky_q;
`endif
    if (clearReq) begin
      stamp_d = '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        cnt_d[c] = '0;
      end
`ifdef RSD_PERF_COUNTER_SATURATE_EN
      sticky_d = '0;
`endif
    end else if (enable) begin
      stamp_d = stamp_q + COUNTER_WIDTH'(1);
      for (int c = 0; c < CHANNEL_NUM; c++) begin
`ifdef RSD_PERF_COUNTER_SATURATE_EN
        if (sat_sum[c][COUNTER_WIDTH]) begin
          cnt_d[c]    = '1;
          sticky_d[c] = 1'b1;
        end else begin
          cnt_d[c] = sat_sum[c][COUNTER_WIDTH-1:0];
        end
`else
        cnt_d[c] = cnt_q[c] + COUNTER_WIDTH'(eventInc[c*INC_WIDTH +: INC_WIDTH]);
`endif
      end
    end
  end

  // Snapshot payload built from the registered values, i.e. before this
  // cycle's increment or clear takes effect.
  always_comb begin
    snap_word[0] = stamp_q;
    for (int c = 0; c < CHANNEL_NUM; c++) begin
      snap_word[c+1] = cnt_q[c];
`ifdef RSD_PERF_COUNTER_SATURATE_EN
      if (sticky_q[c]) begin
        snap_word[c+1][COUNTER_WIDTH-1] = 1'b1;
      end
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // FIFO control. A push into a full FIFO is still accepted when the head is
  // popped on the same edge, because that pop frees the slot being written.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_empty   = (head_q == tail_q);
    fifo_full    = (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]) &&
                   (head_q[IDX_W] != tail_q[IDX_W]);
    pop          = valid_q & outReady & last_q;
    push         = snapshotReq & (~fifo_full | pop);
    drop         = snapshotReq & fifo_full & ~pop;
    head_d       = head_q + CNT_W'(pop);
    tail_d       = tail_q + CNT_W'(push);
    fifo_count_d = tail_d - head_d;
    drop_d       = drop_q;
    if (drop && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stamp_q <= '0;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        cnt_q[c] <= '0;
      end
`ifdef RSD_PERF_COUNTER_SATURATE_EN
      sticky_q <= '0;
`endif
      head_q <= '0;
      tail_q <= '0;
      drop_q <= '0;
    end else begin
      stamp_q <= stamp_d;
      for (int c = 0; c < CHANNEL_NUM; c++) begin
        cnt_q[c] <= cnt_d[c];
      end
`ifdef RSD_PERF_COUNTER_SATURATE_EN
      sticky_q <= sticky_d;
`endif
      head_q <= head_d;
      tail_q <= tail_d;
      drop_q <= drop_d;
    end
  end

  // Storage has no reset. The pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      for (int w = 0; w < WORDS; w++) begin
        fifo_mem[tail_q[IDX_W-1:0]][w] <= snap_word[w];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stream FSM. After the final-beat handshake, the FSM uses the post-pop
  // occupancy to decide whether to restart at beat 0 without an idle cycle.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    valid_d  = valid_q;
    last_d   = last_q;
    beat_inc = beat_q + CH_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d = ST_STREAM;
          beat_d  = '0;
          valid_d = 1'b1;
          last_d  = 1'b0;
        end
      end
      ST_STREAM: begin
        if (valid_q && outReady) begin
          if (last_q) begin
            beat_d = '0;
            last_d = 1'b0;
            if (fifo_count_d == '0) begin
              state_d = ST_IDLE;
              valid_d = 1'b0;
            end
          end else begin
            beat_d = beat_inc;
            last_d = (beat_inc == CH_W'(CHANNEL_NUM));
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  // The read uses registered indices, so the payload stays stable under
  // backpressure. It is forced to zero whenever no beat is being offered.
  assign outValid   = valid_q;
  assign outChannel = beat_q;
  assign outLast    = last_q;
  assign outData    = valid_q ? fifo_mem[head_q[IDX_W-1:0]][beat_q] : '0;
  assign fifoCount  = tail_q - head_q;
  assign dropCount  = drop_q;

endmodule

// File: tb/tb_perf_event_sampler.sv
// tb_perf_event_sampler
//
// Purpose:
//   Directed bench for perf_event_sampler with 8 channels, 8-bit counters,
//   2-bit increments and a 4-entry FIFO. Inputs change 1 time unit after the
//   rising edge. Outputs are sampled on the falling edge.
//   Expected words are hand-computed constants.

module tb_perf_event_sampler;

  localparam int CHANNEL_NUM    = 8;
  localparam int COUNTER_WIDTH  = 8;
  localparam int INC_WIDTH      = 2;
  localparam int SNAPSHOT_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] eventInc;
  logic        clearReq;
  logic        snapshotReq;
  logic        outValid;
  logic        outReady;
  logic [7:0]  outData;
  logic [3:0]  outChannel;
  logic        outLast;
  logic [2:0]  fifoCount;
  logic [7:0]  dropCount;

  int          total = 0;
  int          bad   = 0;
  logic [7:0]  expWords [9];
  logic [7:0]  satExpect;

  perf_event_sampler #(
    .CHANNEL_NUM   (CHANNEL_NUM),
    .COUNTER_WIDTH (COUNTER_WIDTH),
    .INC_WIDTH     (INC_WIDTH),
    .SNAPSHOT_DEPTH(SNAPSHOT_DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .eventInc   (eventInc),
    .clearReq   (clearReq),
    .snapshotReq(snapshotReq),
    .outValid   (outValid),
    .outReady   (outReady),
    .outData    (outData),
    .outChannel (outChannel),
    .outLast    (outLast),
    .fifoCount  (fifoCount),
    .dropCount  (dropCount)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one input pattern for n cycles, then returns all request inputs to 0.
  task automatic applyStimulus(input logic en, input logic [15:0] inc,
                               input logic clr, input logic snap, input int n);
    enable      = en;
    eventInc    = inc;
    clearReq    = clr;
    snapshotReq = snap;
    cycles(n);
    enable      = 1'b0;
    eventInc    = '0;
    clearReq    = 1'b0;
    snapshotReq = 1'b0;
  endtask

  task automatic setExp(input logic [7:0] stamp);
    for (int i = 0; i < 9; i++) expWords[i] = 8'd0;
    expWords[0] = stamp;
  endtask

  // Consumes one full snapshot with outReady=1 and compares it against expWords.
  task automatic streamCheck(input string tag);
    int waited;
    outReady = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!outValid && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    if (!outValid) begin
      checkOutput($sformatf("%s.timeout", tag), 32'd0, 32'd1);
      return;
    end
    for (int b = 0; b < 9; b++) begin
      if (b > 0) @(negedge clk);
      checkOutput($sformatf("%s.valid[%0d]", tag, b), 32'(outValid), 32'd1);
      checkOutput($sformatf("%s.chan[%0d]", tag, b), 32'(outChannel), 32'(b));
      checkOutput($sformatf("%s.data[%0d]", tag, b), 32'(outData), 32'(expWords[b]));
      checkOutput($sformatf("%s.last[%0d]", tag, b), 32'(outLast), 32'(b == 8));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int waited;
    rst         = 1'b1;
    enable      = 1'b0;
    eventInc    = '0;
    clearReq    = 1'b0;
    snapshotReq = 1'b0;
    outReady    = 1'b0;
`ifdef RSD_PERF_COUNTER_SATURATE_EN
    satExpect = 8'd255;
`else
    satExpect = 8'd1;
`endif

    // Reset state
    @(negedge clk);
    checkOutput("rst.valid", 32'(outValid), 32'd0);
    checkOutput("rst.last", 32'(outLast), 32'd0);
    checkOutput("rst.chan", 32'(outChannel), 32'd0);
    checkOutput("rst.data", 32'(outData), 32'd0);
    checkOutput("rst.fifo", 32'(fifoCount), 32'd0);
    checkOutput("rst.drop", 32'(dropCount), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Counting: ch0 += 3 and ch5 += 1 for 10 cycles, then snapshot
    applyStimulus(1'b1, 16'h0403, 1'b0, 1'b0, 10);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    setExp(8'd10);
    expWords[1] = 8'd30;
    expWords[6] = 8'd10;
    streamCheck("count");
    @(negedge clk);
    checkOutput("count.idleValid", 32'(outValid), 32'd0);
    checkOutput("count.idleFifo", 32'(fifoCount), 32'd0);
    @(posedge clk);
    #1;

    // Clear/snapshot/increment collision with ch1 = 7 and stamp = 3
    outReady = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 16'h000C, 1'b0, 1'b0, 2);
    applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0, 1);
    applyStimulus(1'b1, 16'h0008, 1'b1, 1'b1, 1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    setExp(8'd3);
    expWords[2] = 8'd7;
    streamCheck("collide.pre");
    setExp(8'd0);
    streamCheck("collide.post");

    // Overflow: 6 pushes into a 4-deep FIFO with no consumer
    outReady = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0, 5);
    applyStimulus(1'b1, 16'h0040, 1'b0, 1'b1, 6);
    @(negedge clk);
    checkOutput("ovf.fifo", 32'(fifoCount), 32'd4);
    checkOutput("ovf.drop", 32'(dropCount), 32'd2);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("hold.valid[%0d]", i), 32'(outValid), 32'd1);
      checkOutput($sformatf("hold.chan[%0d]", i), 32'(outChannel), 32'd0);
      checkOutput($sformatf("hold.data[%0d]", i), 32'(outData), 32'd5);
      @(posedge clk);
      #1;
    end

    // Full FIFO: push on the same edge as the final-beat pop
    outReady = 1'b1;
    for (int b = 0; b < 9; b++) begin
      @(negedge clk);
      checkOutput($sformatf("popPush.chan[%0d]", b), 32'(outChannel), 32'(b));
      checkOutput($sformatf("popPush.data[%0d]", b), 32'(outData),
                  (b == 0 || b == 4) ? 32'd5 : 32'd0);
      checkOutput($sformatf("popPush.last[%0d]", b), 32'(outLast), 32'(b == 8));
      if (b == 8) snapshotReq = 1'b1;
      @(posedge clk);
      #1;
      snapshotReq = 1'b0;
    end
    outReady = 1'b0;
    @(negedge clk);
    checkOutput("popPush.fifo", 32'(fifoCount), 32'd4);
    checkOutput("popPush.drop", 32'(dropCount), 32'd2);
    checkOutput("popPush.valid", 32'(outValid), 32'd1);
    checkOutput("popPush.chan", 32'(outChannel), 32'd0);
    checkOutput("popPush.data", 32'(outData), 32'd6);
    @(posedge clk);
    #1;
    setExp(8'd6);  expWords[4] = 8'd6;  streamCheck("drain6");
    setExp(8'd7);  expWords[4] = 8'd7;  streamCheck("drain7");
    setExp(8'd8);  expWords[4] = 8'd8;  streamCheck("drain8");
    setExp(8'd11); expWords[4] = 8'd11; streamCheck("drain11");

    // Wrap or saturate: ch2 reaches 254, then +3
    outReady = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0, 127);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    applyStimulus(1'b1, 16'h0030, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    setExp(8'd127); expWords[3] = 8'd254;    streamCheck("wrap.pre");
    setExp(8'd128); expWords[3] = satExpect; streamCheck("wrap.post");
    outReady = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1);
    applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    setExp(8'd1); expWords[3] = 8'd1; streamCheck("wrap.cleared");

    // Reset mid-stream at beat 3
    outReady = 1'b0;
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 2);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    outReady = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!outValid && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("midRst.started", 32'(outValid), 32'd1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("midRst.beat", 32'(outChannel), 32'd3);
    rst = 1'b1;
    #1;
    checkOutput("midRst.valid", 32'(outValid), 32'd0);
    checkOutput("midRst.fifo", 32'(fifoCount), 32'd0);
    checkOutput("midRst.drop", 32'(dropCount), 32'd0);
    checkOutput("midRst.chan", 32'(outChannel), 32'd0);
    @(posedge clk);
    #1;
    rst      = 1'b0;
    outReady = 1'b0;
    applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0, 1);
    applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1, 1);
    setExp(8'd1); expWords[1] = 8'd1; streamCheck("afterRst");
    @(negedge clk);
    checkOutput("end.valid", 32'(outValid), 32'd0);
    checkOutput("end.fifo", 32'(fifoCount), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/perf_event_sampler.md
Name: perf_event_sampler

Overview:
- Parametrised performance-counter block, successor to the fixed debug perfCounter set (IC miss, load miss, branch mispredict, ...).
- Provides CHANNEL_NUM event counters. Each counter accepts a multi-event increment per cycle, so commit-width events can be counted directly.
- Software or a trigger takes timestamped snapshots of all counters. Snapshots are held in a FIFO and streamed out one channel per beat over a valid/ready port.
- Sits beside the debug register path; the simulation dumper or a debug bus is the stream consumer.

Parameters:
- CHANNEL_NUM, 8, number of event counters.
- COUNTER_WIDTH, 32, bits per counter and per cycle stamp.
- INC_WIDTH, 2, bits of per-cycle increment per channel (0..3).
- SNAPSHOT_DEPTH, 4, snapshot FIFO entries; must be a power of two, at least 2.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous active-high reset.
- enable, in, 1, counters and cycle stamp advance only while 1.
- eventInc, in, CHANNEL_NUM*INC_WIDTH, per-channel increment; channel c occupies bits [c*INC_WIDTH +: INC_WIDTH].
- clearReq, in, 1, zero all counters and the cycle stamp.
- snapshotReq, in, 1, capture all counters plus the cycle stamp.
- outValid, out, 1, stream beat valid.
- outReady, in, 1, consumer accepts beat.
- outData, out, COUNTER_WIDTH, beat payload.
- outChannel, out, $clog2(CHANNEL_NUM+1), 0 = cycle stamp; 1..CHANNEL_NUM = counter c-1.
- outLast, out, 1, final beat of a snapshot.
- fifoCount, out, $clog2(SNAPSHOT_DEPTH+1), snapshots currently held.
- dropCount, out, 8, snapshot requests lost because the FIFO was full; saturates at 255.

Behaviour:
- Reset (async, rst=1): all counters, cycle stamp, FIFO pointers, fifoCount, dropCount = 0; FSM = IDLE; outValid = 0, outLast = 0, outChannel = 0, outData = 0.
- Counting:
  - Each cycle with enable=1: counter[c] += eventInc[c], zero-extended; cycle stamp += 1.
  - Arithmetic is modulo 2^COUNTER_WIDTH (wrap-around) unless the optional feature is compiled in.
- Clear:
  - clearReq=1 sets all counters and the stamp to 0 next cycle.
  - Clear wins over a same-cycle increment; that cycle's increment is lost.
  - Clear does not touch the FIFO or dropCount.
- Snapshot:
  - snapshotReq=1 captures the register values present at that clock edge, i.e. before the same-cycle increment or clear.
  - The snapshot is written to the FIFO tail on that edge, so fifoCount rises 1 cycle later.
  - FIFO full and no pop on the same edge: the snapshot is dropped and dropCount += 1.
  - FIFO full with a pop (final-beat handshake) on the same edge: the push is accepted and fifoCount is unchanged.
- Stream FSM:
  - IDLE: if fifoCount != 0, go to STREAM with beat index = 0. outValid stays 0 in IDLE.
  - STREAM:
    - outValid = 1; outData = head entry word[beat]; outChannel = beat; outLast = (beat == CHANNEL_NUM).
    - Beat index advances only on outValid & outReady.
    - outData, outChannel and outLast stay stable while outValid=1 and outReady=0.
    - On the handshake of the last beat: pop the head. If fifoCount after the pop is nonzero, stay in STREAM with beat = 0, giving a back-to-back stream with no idle cycle. Otherwise go to IDLE.
  - Beat 0 of a snapshot appears on the cycle after fifoCount becomes 1 (IDLE -> STREAM latency = 1 cycle).
- Pointer wrap: head and tail carry an extra wrap bit. FIFO full when the indices are equal and the wrap bits differ; empty when both are equal.
- A clearReq while streaming does not alter data already captured in the FIFO.

Optional Feature:
- Macro RSD_PERF_COUNTER_SATURATE_EN.
- Defined:
  - Counters saturate at all-ones instead of wrapping.
  - A per-channel sticky overflow bit is set when saturation occurs and is cleared only by clearReq or reset.
  - The sticky bit is reported in the MSB of the beat: outData[COUNTER_WIDTH-1] is forced to 1 for any channel whose sticky bit was set when the snapshot was captured.
  - The cycle stamp still wraps.
- Undefined: modulo wrap; no sticky bits.

Test Plan:
- Reset mid-stream (rst pulsed while outValid=1, beat 3) -> outValid=0, fifoCount=0, dropCount=0 in the same cycle. After release, all counters restart from 0.
- Counting and snapshot: CHANNEL_NUM=8, enable=1, eventInc ch0=3 and ch5=1 each cycle for 10 cycles, snapshotReq on cycle 10, outReady=1 -> 9 beats: stamp=10, ch0=30, ch5=10, others 0; outLast only on beat 8.
- Clear/snapshot/increment collision: clearReq, snapshotReq and eventInc ch1=2 in the same cycle with ch1=7 -> snapshot shows ch1=7; counter is 0 the next cycle.
- FIFO overflow: 6 snapshotReq pulses with outReady=0 and SNAPSHOT_DEPTH=4 -> fifoCount=4, dropCount=2. Head beats hold stable across 5 cycles of backpressure.
- Full FIFO with pop and push on the same edge: fifoCount stays 4, dropCount unchanged. The next snapshot starts on the following cycle with outChannel=0.
- Wrap: COUNTER_WIDTH=8, ch2 preset to 254, inc 3 -> ch2=1 without the macro. With RSD_PERF_COUNTER_SATURATE_EN: 255 with sticky set, next snapshot outData=0xFF; clearReq clears the sticky bit.
